// File: rtl/riscv_data_mem_slave.sv
// Data-memory slave for the RI5CY req/gnt/rvalid data port: word SRAM with byte
// enables, programmable grant wait states and an error response outside the window.
module riscv_data_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned DEPTH     = 1 << (ADDR_WIDTH - 2);
  localparam logic [31:0] WIN_BYTES = 32'(1) << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_TGT  = 4'(WAIT_STATES);

  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-3:0] word;
  logic [3:0]            wcnt;

  always_comb begin
    offset     = data_addr_i - BASE_ADDR;
    in_range   = (offset < WIN_BYTES);
    word       = offset[ADDR_WIDTH-1:2];
    data_gnt_o = data_req_i & (wcnt == WAIT_TGT) & ~rst_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt <= '0;
    end else if (!data_req_i || data_gnt_o) begin
      wcnt <= '0;
    end else if (wcnt != WAIT_TGT) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  // Grant already carries ~rst_i, so a write at an edge with reset high is dropped.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (data_be_i[i]) mem[word][i*8 +: 8] <= data_wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      if (data_gnt_o) begin
        data_err_o   <= ~in_range;
        data_rdata_o <= (in_range && !data_we_i) ? mem[word] : '0;
      end else begin
        data_err_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_mem_slave.sv
// Directed bench for riscv_data_mem_slave: one instance with no wait states and
// one with three, sharing clock, reset and request payload.
module tb_riscv_data_mem_slave;

  logic        clk, rst;
  logic        req0, req3, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt0, rvalid0, err0, gnt3, rvalid3, err3;
  logic [31:0] rdata0, rdata3;

  int checks = 0;
  int passes = 0;

  riscv_data_mem_slave #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_rvalid_o(rvalid0), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rdata0), .data_err_o(err0)
  );

  riscv_data_mem_slave #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_gnt_o(gnt3),
    .data_rvalid_o(rvalid3), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rdata3), .data_err_o(err3)
  );

  always #5 clk = ~clk;

  // One transaction on the zero-wait instance; entered and left at posedge+1.
  task automatic access0(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, output logic g, output logic rv,
                         output logic er, output logic [31:0] rd);
    req0 = 1'b1; we = w; be = b; addr = a; wdata = d;
    #4 g = gnt0;
    @(posedge clk); #1;
    req0 = 1'b0;
    rv = rvalid0; rd = rdata0; er = err0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 req0 = 1'b1; req3 = 1'b1;
    #3;
    checks++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0: got %b expected 0", gnt0); else passes++;
    checks++; if (gnt3 !== 1'b0) $display("FAIL rst_gnt3: got %b expected 0", gnt3); else passes++;
    checks++; if (rvalid0 !== 1'b0) $display("FAIL rst_rvalid0: got %b expected 0", rvalid0); else passes++;
    checks++; if (rvalid3 !== 1'b0) $display("FAIL rst_rvalid3: got %b expected 0", rvalid3); else passes++;
    checks++; if (err0 !== 1'b0) $display("FAIL rst_err0: got %b expected 0", err0); else passes++;
    checks++; if (rdata0 !== 32'h0) $display("FAIL rst_rdata0: got %h expected 00000000", rdata0); else passes++;
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b0) $display("FAIL rst_hold_rvalid0: got %b expected 0", rvalid0); else passes++;
    req0 = 1'b0; req3 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic g, rv, er;
    logic [31:0] rd;
    access0(1'b1, 4'hF, 32'h0010_0004, 32'hDEAD_BEEF, g, rv, er, rd);
    checks++; if (g !== 1'b1) $display("FAIL wr_gnt: got %b expected 1", g); else passes++;
    checks++; if (rv !== 1'b1) $display("FAIL wr_rvalid: got %b expected 1", rv); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL wr_rdata: got %h expected 00000000", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL wr_err: got %b expected 0", er); else passes++;
    access0(1'b0, 4'hF, 32'h0010_0004, 32'h0, g, rv, er, rd);
    checks++; if (g !== 1'b1) $display("FAIL rd_gnt: got %b expected 1", g); else passes++;
    checks++; if (rv !== 1'b1) $display("FAIL rd_rvalid: got %b expected 1", rv); else passes++;
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h expected deadbeef", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL rd_err: got %b expected 0", er); else passes++;
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b0) $display("FAIL idle_rvalid: got %b expected 0", rvalid0); else passes++;
    checks++; if (err0 !== 1'b0) $display("FAIL idle_err: got %b expected 0", err0); else passes++;
  endtask

  task automatic test_byte_enables;
    logic g, rv, er;
    logic [31:0] rd;
    access0(1'b1, 4'hF, 32'h0010_0008, 32'h1122_3344, g, rv, er, rd);
    access0(1'b1, 4'b0101, 32'h0010_0008, 32'hAABB_CCDD, g, rv, er, rd);
    access0(1'b0, 4'hF, 32'h0010_0008, 32'h0, g, rv, er, rd);
    checks++; if (rd !== 32'h11BB_33DD) $display("FAIL be_rdata: got %h expected 11bb33dd", rd); else passes++;
    access0(1'b0, 4'b0001, 32'h0010_0008, 32'h0, g, rv, er, rd);
    checks++; if (rd !== 32'h11BB_33DD) $display("FAIL be_read_unmasked: got %h expected 11bb33dd", rd); else passes++;
  endtask

  task automatic test_out_of_range;
    logic g, rv, er;
    logic [31:0] rd;
    access0(1'b1, 4'hF, 32'h0010_0000, 32'h5A5A_1234, g, rv, er, rd);
    access0(1'b1, 4'hF, 32'h0010_FFFC, 32'h7777_8888, g, rv, er, rd);
    access0(1'b1, 4'hF, 32'h0010_0000, 32'h0, g, rv, er, rd);
    access0(1'b0, 4'hF, 32'h0011_0000, 32'h0, g, rv, er, rd);
    checks++; if (g !== 1'b1) $display("FAIL oor_rd_gnt: got %b expected 1", g); else passes++;
    checks++; if (rv !== 1'b1) $display("FAIL oor_rd_rvalid: got %b expected 1", rv); else passes++;
    checks++; if (er !== 1'b1) $display("FAIL oor_rd_err: got %b expected 1", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL oor_rd_rdata: got %h expected 00000000", rd); else passes++;
    access0(1'b1, 4'hF, 32'h000F_FFFC, 32'hFFFF_FFFF, g, rv, er, rd);
    checks++; if (g !== 1'b1) $display("FAIL oor_wr_gnt: got %b expected 1", g); else passes++;
    checks++; if (er !== 1'b1) $display("FAIL oor_wr_err: got %b expected 1", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL oor_wr_rdata: got %h expected 00000000", rd); else passes++;
    access0(1'b1, 4'hF, 32'h0010_0000, 32'h5A5A_1234, g, rv, er, rd);
    access0(1'b0, 4'hF, 32'h0010_0000, 32'h0, g, rv, er, rd);
    checks++; if (rd !== 32'h5A5A_1234) $display("FAIL oor_mem_base: got %h expected 5a5a1234", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL oor_mem_base_err: got %b expected 0", er); else passes++;
    access0(1'b0, 4'hF, 32'h0010_FFFC, 32'h0, g, rv, er, rd);
    checks++; if (rd !== 32'h7777_8888) $display("FAIL oor_mem_top: got %h expected 77778888", rd); else passes++;
  endtask

  task automatic test_wait_states;
    for (int c = 0; c <= 8; c++) begin
      checks++;
      if (rvalid3 !== ((c == 4) || (c == 8)))
        $display("FAIL ws_rvalid_c%0d: got %b expected %b", c, rvalid3, (c == 4) || (c == 8));
      else passes++;
      if (c == 4) begin
        checks++; if (rdata3 !== 32'h0) $display("FAIL ws_wr_rdata: got %h expected 00000000", rdata3); else passes++;
      end
      if (c == 8) begin
        checks++; if (rdata3 !== 32'hCAFE_F00D) $display("FAIL ws_rd_rdata: got %h expected cafef00d", rdata3); else passes++;
        checks++; if (err3 !== 1'b0) $display("FAIL ws_rd_err: got %b expected 0", err3); else passes++;
      end
      if (c < 4) begin
        req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0010_0010; wdata = 32'hCAFE_F00D;
      end else if (c < 8) begin
        req3 = 1'b1; we = 1'b0;
      end else begin
        req3 = 1'b0;
      end
      #4;
      checks++;
      if (gnt3 !== ((c == 3) || (c == 7)))
        $display("FAIL ws_gnt_c%0d: got %b expected %b", c, gnt3, (c == 3) || (c == 7));
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [4];
    logic [31:0] v [4];
    logic [31:0] exp_rd;
    a = '{32'h0010_0020, 32'h0010_0024, 32'h0010_0028, 32'h0010_002C};
    v = '{32'h0101_0101, 32'h2222_3333, 32'h4545_6767, 32'h89AB_CDEF};
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        exp_rd = ((c - 1) % 2 == 1) ? v[(c - 1) / 2] : 32'h0;
        checks++; if (rvalid0 !== 1'b1) $display("FAIL b2b_rvalid_c%0d: got %b expected 1", c, rvalid0); else passes++;
        checks++; if (rdata0 !== exp_rd) $display("FAIL b2b_rdata_c%0d: got %h expected %h", c, rdata0, exp_rd); else passes++;
        checks++; if (err0 !== 1'b0) $display("FAIL b2b_err_c%0d: got %b expected 0", c, err0); else passes++;
      end
      if (c < 8) begin
        req0 = 1'b1; we = (c % 2 == 0); be = 4'hF; addr = a[c / 2]; wdata = v[c / 2];
      end else begin
        req0 = 1'b0;
      end
      #4;
      checks++; if (gnt0 !== (c < 8)) $display("FAIL b2b_gnt_c%0d: got %b expected %b", c, gnt0, c < 8); else passes++;
      @(posedge clk); #1;
    end
    checks++; if (rvalid0 !== 1'b0) $display("FAIL b2b_tail_rvalid: got %b expected 0", rvalid0); else passes++;
  endtask

  task automatic test_reset_mid;
    logic g, rv, er;
    logic [31:0] rd;
    req0 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0010_0004; req3 = 1'b1;
    #4;
    checks++; if (gnt0 !== 1'b1) $display("FAIL rm_gnt0: got %b expected 1", gnt0); else passes++;
    checks++; if (gnt3 !== 1'b0) $display("FAIL rm_gnt3_early: got %b expected 0", gnt3); else passes++;
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b1) $display("FAIL rm_rvalid_pre: got %b expected 1", rvalid0); else passes++;
    we = 1'b1; wdata = 32'h0BAD_BAD0; rst = 1'b1;
    #1;
    checks++; if (rvalid0 !== 1'b0) $display("FAIL rm_rvalid_drop: got %b expected 0", rvalid0); else passes++;
    checks++; if (gnt0 !== 1'b0) $display("FAIL rm_gnt0_in_rst: got %b expected 0", gnt0); else passes++;
    checks++; if (gnt3 !== 1'b0) $display("FAIL rm_gnt3_in_rst: got %b expected 0", gnt3); else passes++;
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b0) $display("FAIL rm_rvalid_hold: got %b expected 0", rvalid0); else passes++;
    rst = 1'b0; req0 = 1'b0; we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      checks++; if (gnt3 !== (c == 3)) $display("FAIL rm_ws_gnt_c%0d: got %b expected %b", c, gnt3, c == 3); else passes++;
      @(posedge clk); #1;
    end
    req3 = 1'b0;
    checks++; if (rvalid3 !== 1'b1) $display("FAIL rm_ws_rvalid: got %b expected 1", rvalid3); else passes++;
    access0(1'b0, 4'hF, 32'h0010_0004, 32'h0, g, rv, er, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rm_write_suppressed: got %h expected deadbeef", rd); else passes++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req0 = 1'b0; req3 = 1'b0;
    we = 1'b0; be = '0; addr = '0; wdata = '0;
    test_reset;
    test_write_read;
    test_byte_enables;
    test_out_of_range;
    test_wait_states;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
